// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, ALU codes,
// FSM states and the decoded-control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } state_e;

    typedef struct packed {
        logic      reg_write;
        logic      reg_dst;
        logic      mem_read;
        logic      mem_write;
        logic      mem_to_reg;
        logic      alu_src;
        logic      branch;
        alu_ctrl_e alu_control;
    } ctrl_t;

    function automatic logic is_legal(input logic [31:0] ins);
        logic ok;
        ok = 1'b0;
        case (ins[31:26])
            OP_RTYPE: ok = (ins[5:0] inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        c = '0;
        c.alu_control = ALU_ADD;
        case (ins[31:26])
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (ins[5:0])
                    FN_SUB:  c.alu_control = ALU_SUB;
                    FN_AND:  c.alu_control = ALU_AND;
                    FN_OR:   c.alu_control = ALU_OR;
                    FN_SLT:  c.alu_control = ALU_SLT;
                    default: c.alu_control = ALU_ADD;
                endcase
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                c.branch      = 1'b1;
                c.alu_control = ALU_SUB;
            end
            default: c = c;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational MIPS ALU: add/sub wrap, bitwise and/or, signed set-less-than.
module mips_alu
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_ctrl_e        ctrl,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        y = '0;
        case (ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = WIDTH'($signed(a) < $signed(b));
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: one instruction per handshake, executed over 2-5
// cycles through DECODE/EXECUTE/MEMORY/WRITEBACK with internal decode.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NREGS     = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [31:0]              instr,
    input  logic                     load_we,
    input  logic [$clog2(NREGS)-1:0] load_addr,
    input  logic [WIDTH-1:0]         load_data,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic                     is_zero,
    output logic                     branch_taken,
    output logic                     illegal
);

    localparam int RW = $clog2(NREGS);
    localparam int MW = $clog2(MEM_WORDS);

    state_e           state, state_n;
    logic [31:0]      ir;
    ctrl_t            dec, ctrl_q;
    logic [WIDTH-1:0] a_q, b_q, aluout, mdr;
    logic [WIDTH-1:0] imm, alu_b, alu_y, wb_value, fin_value;
    logic             alu_zero;
    logic [RW-1:0]    rs_idx, rt_idx, rd_idx, wb_addr;
    logic [MW-1:0]    mem_idx;
    logic             accept, fin, fin_illegal, fin_branch;
    logic             wb_en, mem_we, mem_access, load_en;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] mem  [MEM_WORDS];

    assign rs_idx     = RW'(ir[25:21]);
    assign rt_idx     = RW'(ir[20:16]);
    assign rd_idx     = RW'(ir[15:11]);
    assign imm        = WIDTH'($signed(ir[15:0]));
    assign dec        = decode(ir);
    assign alu_b      = ctrl_q.alu_src ? imm : b_q;
    assign mem_idx    = aluout[MW+1:2];
    assign mem_access = ctrl_q.mem_read | ctrl_q.mem_write;
    assign wb_addr    = ctrl_q.reg_dst ? rd_idx : rt_idx;
    assign wb_value   = ctrl_q.mem_to_reg ? mdr : aluout;
    assign load_en    = load_we && (state == S_IDLE);

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign dbg_data    = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    mips_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (a_q),
        .b    (alu_b),
        .ctrl (ctrl_q.alu_control),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // fin marks the edge on which the FSM returns to IDLE and done is raised.
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        fin         = 1'b0;
        fin_illegal = 1'b0;
        fin_branch  = 1'b0;
        fin_value   = '0;
        wb_en       = 1'b0;
        mem_we      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!is_legal(ir)) begin
                    state_n     = S_IDLE;
                    fin         = 1'b1;
                    fin_illegal = 1'b1;
                end else begin
                    state_n = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (ctrl_q.branch) begin
                    state_n    = S_IDLE;
                    fin        = 1'b1;
                    fin_value  = alu_y;
                    fin_branch = alu_zero;
                end else if (mem_access && alu_y[1:0] != 2'b00) begin
                    state_n     = S_IDLE;
                    fin         = 1'b1;
                    fin_illegal = 1'b1;
                    fin_value   = alu_y;
                end else if (mem_access) begin
                    state_n = S_MEMORY;
                end else begin
                    state_n = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (ctrl_q.mem_write) begin
                    state_n   = S_IDLE;
                    fin       = 1'b1;
                    fin_value = aluout;
                    mem_we    = 1'b1;
                end else begin
                    state_n = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                state_n   = S_IDLE;
                fin       = 1'b1;
                fin_value = wb_value;
                wb_en     = ctrl_q.reg_write;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done         <= 1'b0;
            result       <= '0;
            is_zero      <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            done <= fin;
            if (fin) begin
                result       <= fin_value;
                is_zero      <= (fin_value == '0);
                branch_taken <= fin_branch;
                illegal      <= fin_illegal;
            end
        end
    end

    // Writeback and preload are mutually exclusive by state; register 0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_value;
        end else if (load_en && load_addr != '0) begin
            regs[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) ir <= instr;
        if (state == S_DECODE) begin
            a_q    <= regs[rs_idx];
            b_q    <= regs[rt_idx];
            ctrl_q <= dec;
        end
        if (state == S_EXECUTE) aluout <= alu_y;
        if (state == S_MEMORY)  mdr    <= mem[mem_idx];
    end

    // NOTE: the data memory has no reset so it maps onto plain RAM; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) mem[mem_idx] <= b_q;
    end

endmodule
